buffer_filler: RTL and testbench

Producer side of the shared 256x32 ping-pong word buffer between the ARM-side emulator and the FPGA consumer. After boot it pre-fills the lower half. It then answers each consumer fill request (fillBuffer) by acknowledging it and rewriting the idle half, alternating upper/lower. While writing it drives the per-half busy flags, which the consumer checks to detect underrun.

---
 rtl/buffer_pkg.sv | 22 ++
 rtl/fill_data_gen.sv | 38 +++
 rtl/buffer_filler.sv | 142 ++++++++++++++
 tb/tb_buffer_filler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg: geometry and filler state encoding shared by the ping-pong buffer producer.
`default_nettype none

package buffer_pkg;

  localparam int BUF_ADDR_W = 8;
  localparam int BUF_DATA_W = 32;
  localparam int HALF_WORDS = 128;

  localparam logic [BUF_ADDR_W-1:0] LOWER_BASE = 8'h00;
  localparam logic [BUF_ADDR_W-1:0] UPPER_BASE = 8'h80;

  typedef enum logic [1:0] {
    BOOT_WAIT = 2'd0,
    BOOT_FILL = 2'd1,
    IDLE      = 2'd2,
    FILL      = 2'd3
  } filler_state_e;

endpackage

`default_nettype wire

// File: rtl/fill_data_gen.sv
// fill_data_gen: word source for buffer fills, advances once per write.
// Build option FILLER_DATA_LFSR_EN selects a Galois LFSR instead of a counter.
`default_nettype none

module fill_data_gen
  import buffer_pkg::*;
#(
  parameter logic [BUF_DATA_W-1:0] SEED = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  output logic [BUF_DATA_W-1:0] value
);

`ifdef FILLER_DATA_LFSR_EN
  // x^32+x^22+x^2+x+1, right-shifting Galois form; an all-zero state would lock up
  localparam logic [BUF_DATA_W-1:0] TAPS  = 32'h8020_0003;
  localparam logic [BUF_DATA_W-1:0] START = (SEED == '0) ? 32'h0000_0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= START;
    else if (step)
      value <= {1'b0, value[BUF_DATA_W-1:1]} ^ (value[0] ? TAPS : '0);
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= SEED;
    else if (step)
      value <= value + 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/buffer_filler.sv
// buffer_filler: producer for the 256x32 ping-pong buffer; boot-fills the lower half,
// then refills the idle half on each consumer request. Data option: FILLER_DATA_LFSR_EN.
`default_nettype none

module buffer_filler
  import buffer_pkg::*;
#(
  parameter int                    BOOT_DELAY = 16,
  parameter int                    WRITE_GAP  = 1,
  parameter logic [BUF_DATA_W-1:0] DATA_SEED  = 32'h0000_0001
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  fillBuffer,
  output logic                  msgToFillBufferWasReceived,
  output logic                  fillingFirstPosition,
  output logic                  fillingFinalPosition,
  output logic                  componentTofillBufferIsBotting,
  output logic [BUF_ADDR_W-1:0] wrAddress,
  output logic [BUF_DATA_W-1:0] wrData,
  output logic                  wrEnable,
  output logic                  overrun,
  output logic [15:0]           fillsDone
);

  localparam int DLY_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam int GAP_W = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;
  localparam logic [6:0] LAST_OFS = 7'(HALF_WORDS - 1);

  filler_state_e         state, state_next;
  logic [DLY_W-1:0]      delay_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [6:0]            wr_offset;
  logic                  next_upper;
  logic                  enter_fill, start_fill, write_now, fill_end, last_written;
  logic [BUF_DATA_W-1:0] gen_value;

  assign last_written = wrEnable && (wrAddress[6:0] == LAST_OFS);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= BOOT_WAIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter_fill = 1'b0;
    start_fill = 1'b0;
    write_now  = 1'b0;
    fill_end   = 1'b0;
    unique case (state)
      BOOT_WAIT: begin
        if (delay_cnt == DLY_W'(BOOT_DELAY - 1)) begin
          state_next = BOOT_FILL;
          enter_fill = 1'b1;
        end
      end
      BOOT_FILL, FILL: begin
        if (last_written) begin
          state_next = IDLE;
          fill_end   = 1'b1;
        end else if (gap_cnt == '0) begin
          write_now = 1'b1;
        end
      end
      IDLE: begin
        // a still-high ack means the consumer has not yet withdrawn the request just served
        if (fillBuffer && !msgToFillBufferWasReceived) begin
          state_next = FILL;
          start_fill = 1'b1;
          enter_fill = 1'b1;
        end
      end
      default: state_next = BOOT_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      delay_cnt                      <= '0;
      gap_cnt                        <= '0;
      wr_offset                      <= '0;
      next_upper                     <= 1'b1;
      msgToFillBufferWasReceived     <= 1'b0;
      fillingFirstPosition           <= 1'b0;
      fillingFinalPosition           <= 1'b0;
      componentTofillBufferIsBotting <= 1'b1;
      wrAddress                      <= '0;
      wrData                         <= '0;
      wrEnable                       <= 1'b0;
      overrun                        <= 1'b0;
      fillsDone                      <= '0;
    end else begin
      wrEnable <= write_now;
      if (state == BOOT_WAIT)
        delay_cnt <= delay_cnt + 1'b1;

      if (enter_fill) begin
        gap_cnt              <= '0;
        wr_offset            <= '0;
        fillingFirstPosition <= !start_fill || !next_upper;
        fillingFinalPosition <= start_fill && next_upper;
      end else if (write_now) begin
        wrAddress <= (fillingFinalPosition ? UPPER_BASE : LOWER_BASE) | {1'b0, wr_offset};
        wrData    <= gen_value;
        wr_offset <= wr_offset + 1'b1;
        gap_cnt   <= GAP_W'(WRITE_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      // the half just written becomes the busy one; the other is served next
      if (fill_end) begin
        next_upper                     <= fillingFirstPosition;
        fillingFirstPosition           <= 1'b0;
        fillingFinalPosition           <= 1'b0;
        componentTofillBufferIsBotting <= 1'b0;
        fillsDone                      <= fillsDone + 1'b1;
      end

      if (start_fill)
        msgToFillBufferWasReceived <= 1'b1;
      else if (!fillBuffer)
        msgToFillBufferWasReceived <= 1'b0;

      if (state == FILL && fillBuffer && !msgToFillBufferWasReceived)
        overrun <= 1'b1;
    end
  end

  fill_data_gen #(
    .SEED (DATA_SEED)
  ) u_gen (
    .clk   (clock),
    .rst_n (resetN),
    .step  (write_now),
    .value (gen_value)
  );

endmodule

`default_nettype wire

// File: tb/tb_buffer_filler.sv
// tb_buffer_filler: directed bench with a write scoreboard for buffer_filler (default parameters).
`default_nettype none

module tb_buffer_filler;

  logic        clock = 1'b0;
  logic        resetN;
  logic        fillBuffer;
  logic        ack, first_pos, final_pos, booting, wr_en, overrun;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] fills_done;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  logic [31:0] exp_val;

  buffer_filler dut (
    .clock                          (clock),
    .resetN                         (resetN),
    .fillBuffer                     (fillBuffer),
    .msgToFillBufferWasReceived     (ack),
    .fillingFirstPosition           (first_pos),
    .fillingFinalPosition           (final_pos),
    .componentTofillBufferIsBotting (booting),
    .wrAddress                      (wr_addr),
    .wrData                         (wr_data),
    .wrEnable                       (wr_en),
    .overrun                        (overrun),
    .fillsDone                      (fills_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] gen_next(input logic [31:0] v);
`ifdef FILLER_DATA_LFSR_EN
    logic [31:0] n;
    n = v >> 1;
    if (v[0]) begin
      n[31] = n[31] ^ 1'b1;
      n[21] = n[21] ^ 1'b1;
      n[1]  = n[1]  ^ 1'b1;
      n[0]  = n[0]  ^ 1'b1;
    end
    return n;
`else
    return v + 32'd1;
`endif
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input logic [7:0] base);
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back({base + 8'(i), exp_val});
      exp_val = gen_next(exp_val);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, {wr_addr, wr_data}, 40'h0);
    check({tag, "_ctl"}, {32'h0, wr_en, ack, first_pos, final_pos, booting, overrun, 2'b00},
          {32'h0, 8'b0000_1000});
    check({tag, "_fills"}, {24'h0, fills_done}, 40'h0);
  endtask

  // counts edges until the given flag is sampled low; returns -1 on timeout
  task automatic wait_flag_low(input int which, output int n);
    n = 0;
    forever begin
      @(posedge clock); #1;
      n++;
      if ((which == 0 && !first_pos) || (which == 1 && !final_pos) ||
          (which == 2 && !booting)) break;
      if (n > 1000) begin n = -1; break; end
    end
  endtask

  // scoreboard: every DUT write is popped and compared, along with flag sanity
  always @(negedge clock) begin
    if (resetN === 1'b1 && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {wr_addr, wr_data}, 40'h0);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("write", {wr_addr, wr_data}, e);
        check("flags", {38'h0, first_pos, final_pos}, {38'h0, !e[39], e[39]});
      end
    end
  end

  initial begin
    int n;
    resetN     = 1'b0;
    fillBuffer = 1'b0;
    exp_val    = 32'h0000_0001;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");

    // boot: 16 wait cycles + 256 fill cycles with booting high
    @(negedge clock); resetN = 1'b1; push_fill(8'h00);
    wait_flag_low(2, n);
    check("boot_len", 40'(n), 40'd272);
    check("boot_done", {fills_done, 6'h0, first_pos, final_pos, 16'h0}, {16'd1, 24'h0});
    check("boot_q", 40'(exp_q.size()), 40'd0);

    // first request: upper half, ack held while request held
    repeat (3) @(negedge clock);
    fillBuffer = 1'b1; push_fill(8'h80);
    @(posedge clock); #1;
    check("req1_ack", {38'h0, ack, final_pos}, 40'b11);
    @(negedge clock);
    @(posedge clock); #1;
    check("req1_ack_hold", {39'h0, ack}, 40'd1);
    @(negedge clock); fillBuffer = 1'b0;
    @(posedge clock); #1;
    check("req1_ack_clr", {39'h0, ack}, 40'd0);
    wait_flag_low(1, n);
    check("req1_len", 40'(n), 40'd254);
    check("req1_done", {24'h0, fills_done}, 40'd2);
    check("req1_q", 40'(exp_q.size()), 40'd0);

    // second request alternates back to lower half
    @(negedge clock); fillBuffer = 1'b1; push_fill(8'h00);
    @(posedge clock); #1;
    check("req2_ack", {37'h0, ack, first_pos, final_pos}, 40'b110);
    @(negedge clock); fillBuffer = 1'b0;
    wait_flag_low(0, n);
    check("req2_done", {24'h0, fills_done}, 40'd3);
    check("req2_q", 40'(exp_q.size()), 40'd0);

    // overrun: request raised mid upper fill is flagged, then serviced afterwards
    @(negedge clock); fillBuffer = 1'b1; push_fill(8'h80);
    @(negedge clock); fillBuffer = 1'b0;
    repeat (20) @(negedge clock);
    fillBuffer = 1'b1; push_fill(8'h00);
    @(posedge clock); #1;
    check("ovr_set", {38'h0, overrun, ack}, 40'b10);
    n = 0;
    while (!ack && n < 1000) begin @(posedge clock); #1; n++; end
    check("ovr_ack", {23'h0, ack, fills_done}, {23'h0, 1'b1, 16'd4});
    check("ovr_lower", {38'h0, first_pos, final_pos}, 40'b10);
    @(negedge clock); fillBuffer = 1'b0;
    wait_flag_low(0, n);
    check("ovr_done", {23'h0, overrun, fills_done}, {23'h0, 1'b1, 16'd5});
    check("ovr_q", 40'(exp_q.size()), 40'd0);

    // reset in the middle of an upper fill
    @(negedge clock); fillBuffer = 1'b1; push_fill(8'h80);
    @(negedge clock); fillBuffer = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!(wr_en && wr_addr == 8'hC0) && n < 1000);
    check("mid_reached", {32'h0, wr_addr}, 40'hC0);
    #2 resetN = 1'b0;
    #1 check_reset_vals("async_reset");
    exp_q.delete();
    exp_val = 32'h0000_0001;

    // restart: request during boot is ignored
    @(negedge clock); resetN = 1'b1; fillBuffer = 1'b1; push_fill(8'h00);
    repeat (10) @(negedge clock);
    check("boot_ignore", {37'h0, ack, overrun, booting}, 40'b001);
    fillBuffer = 1'b0;
    wait_flag_low(2, n);
    check("reboot_len", 40'(n), 40'd262);
    check("reboot_done", {23'h0, overrun, fills_done}, {23'h0, 1'b0, 16'd1});
    check("reboot_q", 40'(exp_q.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
